// File: rtl/fp_f2d_seq.sv
// fp_f2d_seq: sequential FP32 -> FP64 conversion.
// Zero, infinity, NaN and normal operands resolve in one cycle. Subnormal
// operands are normalised one bit per cycle in NORM until the hidden bit
// reaches bit 23 of the shift register.
module fp_f2d_seq (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] a_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [63:0] result_o,
  output logic        invalid_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    DONE
  } state_t;

  state_t      state_q;
  logic [23:0] shreg_q;
  logic [10:0] wexp_q;
  logic        sign_q;
  logic [63:0] result_q;
  logic        invalid_q;

  logic        a_sign;
  logic [7:0]  a_exp;
  logic [22:0] a_mant;
  logic        a_is_sub;
  logic [63:0] fast_result;
  logic        fast_invalid;
  logic        accept;
  logic [23:0] shifted;
  logic [10:0] wexp_dec;

  // Operand decode and single-cycle result for every non-subnormal class
  always_comb begin
    a_sign       = a_i[31];
    a_exp        = a_i[30:23];
    a_mant       = a_i[22:0];
    a_is_sub     = (a_exp == 8'h00) && (a_mant != 23'd0);
    fast_invalid = 1'b0;
    fast_result  = {a_sign, {3'b000, a_exp} + 11'd896, a_mant, 29'd0};
    if (a_exp == 8'h00) begin
      fast_result = {a_sign, 63'd0};
    end else if (a_exp == 8'hFF) begin
      if (a_mant == 23'd0) begin
        fast_result = {a_sign, 11'h7FF, 52'd0};
      end else begin
        // Forcing the quiet bit covers both NaN kinds: a quiet NaN already has it set.
        fast_result  = {a_sign, 11'h7FF, 1'b1, a_mant[21:0], 29'd0};
        fast_invalid = ~a_mant[22];
      end
    end
  end

  // Handshake and normalisation datapath helpers
  always_comb begin
    in_ready_o  = ~flush_i & ((state_q == IDLE) | ((state_q == DONE) & out_ready_i));
    accept      = in_valid_i & in_ready_o;
    out_valid_o = (state_q == DONE);
    busy_o      = (state_q != IDLE);
    result_o    = result_q;
    invalid_o   = invalid_q;
    shifted     = shreg_q << 1;
    wexp_dec    = wexp_q - 11'd1;
  end

  // Conversion FSM with registered result and flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      wexp_q    <= '0;
      sign_q    <= 1'b0;
      result_q  <= '0;
      invalid_q <= 1'b0;
    end else if (flush_i) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            if (a_is_sub) begin
              state_q <= NORM;
              shreg_q <= {1'b0, a_mant};
              wexp_q  <= 11'd897;
              sign_q  <= a_sign;
            end else begin
              state_q   <= DONE;
              result_q  <= fast_result;
              invalid_q <= fast_invalid;
            end
          end else if ((state_q == DONE) && out_ready_i) begin
            state_q <= IDLE;
          end
        end
        NORM: begin
          shreg_q <= shifted;
          wexp_q  <= wexp_dec;
          if (shifted[23]) begin
            state_q   <= DONE;
            result_q  <= {sign_q, wexp_dec, shifted[22:0], 29'd0};
            invalid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
